// File: rtl/camera_pixel_fifo.sv
// Camera byte-stream capture: pairs OV7670 bytes into RGB565 pixels tagged with
// start-of-frame, and buffers them in a single-clock first-word-fall-through FIFO.
module camera_pixel_fifo #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FIFO_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_data,
  input  logic               en,
  input  logic               rd_en,
  output logic [16:0]        dout,
  output logic [FIFO_AW-1:0] data_count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               line_err,
  output logic               frame_err,
  output logic               frame_done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ARMED      = 2'd1,
    BYTE_HI    = 2'd2,
    BYTE_LO    = 2'd3
  } state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] MAX_COUNT = '1;

  // Input stage
  logic       vsync_q, vsync_qq;
  logic       href_q, href_qq;
  logic [7:0] data_q;
  logic       vsync_fall, vsync_rise, href_rise, href_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      data_q   <= 8'd0;
    end else begin
      vsync_q  <= cam_vsync;
      vsync_qq <= vsync_q;
      href_q   <= cam_href;
      href_qq  <= href_q;
      data_q   <= cam_data;
    end
  end

  assign vsync_fall = vsync_qq & ~vsync_q;
  assign vsync_rise = ~vsync_qq & vsync_q;
  assign href_rise  = ~href_qq & href_q;
  assign href_fall  = href_qq & ~href_q;

  // Capture FSM
  state_t      state, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] pixel_cnt, pixel_cnt_d;
  logic [15:0] line_cnt, line_cnt_d;
  logic        sof_pending, sof_d;
  logic        wr_valid, wr_valid_d;
  logic [16:0] wr_data, wr_data_d;
  logic        frame_done_d, line_err_d, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_FRAME;
      hi_q        <= 8'd0;
      pixel_cnt   <= 16'd0;
      line_cnt    <= 16'd0;
      sof_pending <= 1'b0;
      wr_valid    <= 1'b0;
      wr_data     <= 17'd0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_d;
      hi_q        <= hi_d;
      pixel_cnt   <= pixel_cnt_d;
      line_cnt    <= line_cnt_d;
      sof_pending <= sof_d;
      wr_valid    <= wr_valid_d;
      wr_data     <= wr_data_d;
      frame_done  <= frame_done_d;
      line_err    <= line_err_d;
      frame_err   <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    hi_d         = hi_q;
    pixel_cnt_d  = pixel_cnt;
    line_cnt_d   = line_cnt;
    sof_d        = sof_pending;
    wr_valid_d   = 1'b0;
    wr_data_d    = wr_data;
    frame_done_d = 1'b0;
    line_err_d   = line_err;
    frame_err_d  = frame_err;
    case (state)
      WAIT_FRAME: begin
        if (vsync_fall && en) begin
          state_d    = ARMED;
          line_cnt_d = 16'd0;
          sof_d      = 1'b0;
        end
      end
      default: begin
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          if (line_cnt != 16'(V_ACTIVE)) frame_err_d = 1'b1;
          line_cnt_d = 16'd0;
          sof_d      = 1'b0;
          state_d    = WAIT_FRAME;
        end else if (href_fall && state != ARMED) begin
          line_cnt_d = line_cnt + 16'd1;
          if (state == BYTE_LO || pixel_cnt != 16'(H_ACTIVE)) line_err_d = 1'b1;
          state_d = ARMED;
        end else if (state == ARMED) begin
          // The byte present at href rise is already the first hi byte of the line.
          if (href_rise) begin
            pixel_cnt_d = 16'd0;
            if (line_cnt == 16'd0) sof_d = 1'b1;
            hi_d    = data_q;
            state_d = BYTE_LO;
          end
        end else if (href_q) begin
          if (state == BYTE_HI) begin
            hi_d    = data_q;
            state_d = BYTE_LO;
          end else begin
            wr_valid_d  = 1'b1;
            wr_data_d   = {sof_pending, hi_q, data_q};
            sof_d       = 1'b0;
            pixel_cnt_d = pixel_cnt + 16'd1;
            state_d     = BYTE_HI;
          end
        end
      end
    endcase
  end

  assign dbg_state = state;

  // FWFT FIFO; a pop on the same edge frees the slot for a write even when full
  logic [16:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               do_pop, do_push;

  assign empty   = (data_count == '0);
  assign full    = (data_count == MAX_COUNT);
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_valid & (~full | do_pop);
  assign dout    = empty ? 17'd0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
      if (wr_valid && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule
